river_carry_engine: RTL and testbench

- Parametrised successor to the single-lane frog/log checker. Once per frame, resolves whether the frog stands on a log in any of NUM_ROWS river rows, each row holding NUM_LOGS logs.
- Applies per-row speed and direction to carry the frog, and flags drowning or being swept off screen.
- Sits between the log motion generators and the frog position/lives controller.
- Scans one log per cycle through an FSM with a start/done handshake.

---
 rtl/river_pkg.sv | 25 ++
 rtl/river_log_hit.sv | 22 ++
 rtl/river_carry_engine.sv | 215 +++++++++++++++++++++
 tb/tb_river_carry_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/river_pkg.sv
// Shared types and default dimensions for the river carry engine.
// RIVER_SUBPIXEL_EN (see river_carry_engine) changes how row_speed is interpreted.
package river_pkg;

    localparam int DEF_NUM_ROWS = 4;
    localparam int DEF_NUM_LOGS = 3;
    localparam int DEF_COORD_W  = 10;
    localparam int DEF_SPEED_W  = 4;
    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_FROG_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        FIND_ROW,
        SCAN,
        APPLY,
        DONE
    } state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

endpackage

// File: rtl/river_log_hit.sv
// Combinational overlap test: is the frog centre inside one log's span?
// Arithmetic is one bit wider than a coordinate so the log end never wraps.
module river_log_hit
    import river_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic [COORD_W:0]   frog_cx,
    input  logic [COORD_W-1:0] log_x,
    input  logic [COORD_W-1:0] log_len,
    input  logic               valid,
    output logic               hit
);

    logic [COORD_W:0] log_start;
    logic [COORD_W:0] log_end;

    assign log_start = {1'b0, log_x};
    assign log_end   = {1'b0, log_x} + {1'b0, log_len};
    assign hit       = valid && (log_start <= frog_cx) && (frog_cx < log_end);

endmodule

// File: rtl/river_carry_engine.sv
// Per-frame frog/log resolver: finds the frog's river row, scans its logs one
// per cycle, then applies the row carry. Optional macro: RIVER_SUBPIXEL_EN.
module river_carry_engine
    import river_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int NUM_LOGS = DEF_NUM_LOGS,
    parameter int COORD_W  = DEF_COORD_W,
    parameter int SPEED_W  = DEF_SPEED_W,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int FROG_W   = DEF_FROG_W
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         frame_tick,
    input  logic [COORD_W-1:0]                           frog_x,
    input  logic [COORD_W-1:0]                           frog_y,
    input  logic [NUM_ROWS-1:0][COORD_W-1:0]             row_y,
    input  logic [NUM_ROWS-1:0][SPEED_W-1:0]             row_speed,
    input  logic [NUM_ROWS-1:0]                          row_dir,
    input  logic [NUM_ROWS-1:0][NUM_LOGS-1:0][COORD_W-1:0] log_x,
    input  logic [NUM_ROWS-1:0][NUM_LOGS-1:0][COORD_W-1:0] log_len,
    input  logic [NUM_ROWS-1:0][NUM_LOGS-1:0]            log_valid,
    output logic                                         busy,
    output logic                                         done,
    output logic [COORD_W-1:0]                           frog_x_new,
    output logic                                         frog_on_log,
    output logic                                         frog_in_water,
    output logic                                         frog_swept_off,
    output logic                                         overrun
);

    localparam int ROW_IW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int LOG_IW = (NUM_LOGS > 1) ? $clog2(NUM_LOGS) : 1;
    localparam int CW2    = COORD_W + 2;

    state_t              state, state_nxt;
    logic                start_q;
    logic [COORD_W-1:0]  fx_q, fy_q;
    logic [ROW_IW-1:0]   row_q;
    logic                row_hit_q;
    logic [LOG_IW-1:0]   log_k_q;
    logic                found_q;
    logic                accept;

    assign accept = frame_tick && !busy;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state logic; the tick is captured into start_q first, which gives
    // the fixed NUM_LOGS+3 latency from the sampling edge to done.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:     if (start_q) state_nxt = FIND_ROW;
            FIND_ROW: state_nxt = SCAN;
            SCAN:     if (log_k_q == LOG_IW'(NUM_LOGS - 1)) state_nxt = APPLY;
            APPLY:    state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = start_q || (state != IDLE);
        done = (state == DONE);
    end

    // Lowest matching row wins: the loop walks downward so smaller r overrides.
    logic              row_match;
    logic [ROW_IW-1:0] row_sel;

    always_comb begin
        row_match = 1'b0;
        row_sel   = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (row_y[r] == fy_q) begin
                row_match = 1'b1;
                row_sel   = ROW_IW'(r);
            end
        end
    end

    logic [COORD_W:0] frog_cx;
    logic             log_hit;

    assign frog_cx = {1'b0, fx_q} + (COORD_W + 1)'(FROG_W / 2);

    river_log_hit #(.COORD_W(COORD_W)) u_log_hit (
        .frog_cx (frog_cx),
        .log_x   (log_x[row_q][log_k_q]),
        .log_len (log_len[row_q][log_k_q]),
        .valid   (log_valid[row_q][log_k_q] && row_hit_q),
        .hit     (log_hit)
    );

    // Carry computation used in APPLY
    logic [SPEED_W-1:0] speed;
    dir_t               dir;
    logic [CW2-1:0]     step;
    logic [CW2-1:0]     fx_ext;
    logic [CW2-1:0]     right_sum;
    logic [COORD_W-1:0] x_nxt;
    logic               on_nxt, water_nxt, swept_nxt;

    assign speed  = row_speed[row_q];
    assign dir    = dir_t'(row_dir[row_q]);
    assign fx_ext = CW2'(fx_q);

`ifdef RIVER_SUBPIXEL_EN
    logic [3:0] acc_q;
    logic [4:0] frac_sum;

    assign frac_sum = {1'b0, acc_q} + {1'b0, speed[3:0]};
    assign step     = CW2'(speed >> 4) + CW2'(frac_sum[4]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (state == APPLY) begin
            acc_q <= (row_hit_q && found_q) ? frac_sum[3:0] : 4'd0;
        end
    end
`else
    assign step = CW2'(speed);
`endif

    assign right_sum = fx_ext + step;

    always_comb begin
        x_nxt     = fx_q;
        on_nxt    = 1'b0;
        water_nxt = 1'b0;
        swept_nxt = 1'b0;
        if (row_hit_q) begin
            if (!found_q) begin
                water_nxt = 1'b1;
            end else begin
                on_nxt = 1'b1;
                if (dir == DIR_RIGHT) begin
                    if (right_sum + CW2'(FROG_W) > CW2'(SCREEN_W)) begin
                        swept_nxt = 1'b1;
                        x_nxt     = COORD_W'(SCREEN_W - FROG_W);
                    end else begin
                        x_nxt = right_sum[COORD_W-1:0];
                    end
                end else begin
                    if (fx_ext < step) begin
                        swept_nxt = 1'b1;
                        x_nxt     = '0;
                    end else begin
                        x_nxt = COORD_W'(fx_ext - step);
                    end
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q        <= 1'b0;
            fx_q           <= '0;
            fy_q           <= '0;
            row_q          <= '0;
            row_hit_q      <= 1'b0;
            log_k_q        <= '0;
            found_q        <= 1'b0;
            frog_x_new     <= '0;
            frog_on_log    <= 1'b0;
            frog_in_water  <= 1'b0;
            frog_swept_off <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            start_q <= accept;
            if (accept) begin
                fx_q <= frog_x;
                fy_q <= frog_y;
            end
            if (frame_tick && busy) begin
                overrun <= 1'b1;
            end
            unique case (state)
                FIND_ROW: begin
                    row_q     <= row_sel;
                    row_hit_q <= row_match;
                    log_k_q   <= '0;
                    found_q   <= 1'b0;
                end
                SCAN: begin
                    if (log_hit) found_q <= 1'b1;
                    log_k_q <= log_k_q + 1'b1;
                end
                APPLY: begin
                    frog_x_new     <= x_nxt;
                    frog_on_log    <= on_nxt;
                    frog_in_water  <= water_nxt;
                    frog_swept_off <= swept_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_river_carry_engine.sv
// Directed bench for river_carry_engine with a scoreboard of expected frame results.
module tb_river_carry_engine;
    import river_pkg::*;

    localparam int NUM_ROWS = 4;
    localparam int NUM_LOGS = 3;
    localparam int COORD_W  = 10;
    localparam int SPEED_W  = 4;
    localparam int SCREEN_W = 320;
    localparam int FROG_W   = 32;

    logic clk = 1'b0;
    logic reset;
    logic frame_tick;
    logic [COORD_W-1:0] frog_x, frog_y;
    logic [NUM_ROWS-1:0][COORD_W-1:0] row_y;
    logic [NUM_ROWS-1:0][SPEED_W-1:0] row_speed;
    logic [NUM_ROWS-1:0] row_dir;
    logic [NUM_ROWS-1:0][NUM_LOGS-1:0][COORD_W-1:0] log_x;
    logic [NUM_ROWS-1:0][NUM_LOGS-1:0][COORD_W-1:0] log_len;
    logic [NUM_ROWS-1:0][NUM_LOGS-1:0] log_valid;
    logic busy, done, frog_on_log, frog_in_water, frog_swept_off, overrun;
    logic [COORD_W-1:0] frog_x_new;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic               on;
        logic               water;
        logic               swept;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    river_carry_engine #(
        .NUM_ROWS(NUM_ROWS), .NUM_LOGS(NUM_LOGS), .COORD_W(COORD_W),
        .SPEED_W(SPEED_W), .SCREEN_W(SCREEN_W), .FROG_W(FROG_W)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .frog_x(frog_x), .frog_y(frog_y), .row_y(row_y),
        .row_speed(row_speed), .row_dir(row_dir), .log_x(log_x),
        .log_len(log_len), .log_valid(log_valid), .busy(busy), .done(done),
        .frog_x_new(frog_x_new), .frog_on_log(frog_on_log),
        .frog_in_water(frog_in_water), .frog_swept_off(frog_swept_off),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int x, input bit on, input bit water, input bit swept);
        exp_t e;
        e.x     = COORD_W'(x);
        e.on    = on;
        e.water = water;
        e.swept = swept;
        return e;
    endfunction

    // Called #1 after an edge; leaves control #1 after the edge that sampled the tick.
    task automatic start_frame(input int x, input int y, input exp_t e);
        frog_x     = COORD_W'(x);
        frog_y     = COORD_W'(y);
        frame_tick = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    // Waits (bounded) for done, checks latency counted from now, pops and compares.
    task automatic finish_frame(input string tag, input int lat_exp);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        check({tag, " latency"}, 32'(cyc), 32'(lat_exp));
        check({tag, " x_new"}, 32'(frog_x_new), 32'(e.x));
        check({tag, " on_log"}, 32'(frog_on_log), 32'(e.on));
        check({tag, " in_water"}, 32'(frog_in_water), 32'(e.water));
        check({tag, " swept_off"}, 32'(frog_swept_off), 32'(e.swept));
        @(posedge clk); #1;
        check({tag, " done width"}, 32'(done), 32'd0);
        check({tag, " busy clear"}, 32'(busy), 32'd0);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int cnt;
        reset      = 1'b0;
        frame_tick = 1'b0;
        frog_x     = '0;
        frog_y     = '0;
        row_y      = '0;
        row_speed  = '0;
        row_dir    = '0;
        log_x      = '0;
        log_len    = '0;
        log_valid  = '0;

        // Rows 1 and 3 share y = 64; row 1 must win.
        row_y[0] = 10'd32;  row_y[1] = 10'd64;
        row_y[2] = 10'd96;  row_y[3] = 10'd64;
        row_speed[1] = 4'd2; row_dir[1] = 1'b0;
        row_speed[3] = 4'd9; row_dir[3] = 1'b1;
        log_x[1][0] = 10'd100; log_len[1][0] = 10'd96; log_valid[1][0] = 1'b1;
        log_x[3][0] = 10'd0;   log_len[3][0] = 10'd300; log_valid[3][0] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset x_new", 32'(frog_x_new), 32'd0);
        check("reset flags", {29'd0, frog_on_log, frog_in_water, frog_swept_off}, 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

`ifndef RIVER_SUBPIXEL_EN
        start_frame(120, 64, mk(122, 1, 0, 0));
        finish_frame("carry right", NUM_LOGS + 3);

        // Slot 2 only: centre exactly at log start hits, centre at log end misses.
        log_valid[1][0] = 1'b0;
        log_x[1][2] = 10'd150; log_len[1][2] = 10'd50; log_valid[1][2] = 1'b1;
        start_frame(134, 64, mk(136, 1, 0, 0));
        finish_frame("slot2 start edge", NUM_LOGS + 3);
        start_frame(184, 64, mk(184, 0, 1, 0));
        finish_frame("slot2 end edge", NUM_LOGS + 3);

        row_dir[1] = 1'b1; row_speed[1] = 4'd5;
        log_x[1][0] = 10'd0; log_len[1][0] = 10'd64; log_valid[1][0] = 1'b1;
        start_frame(3, 64, mk(0, 1, 0, 1));
        finish_frame("swept left", NUM_LOGS + 3);

        row_dir[1] = 1'b0; row_speed[1] = 4'd4;
        log_x[1][0] = 10'd250;
        start_frame(286, 64, mk(288, 1, 0, 1));
        finish_frame("swept right", NUM_LOGS + 3);
        start_frame(284, 64, mk(288, 1, 0, 0));
        finish_frame("right edge exact", NUM_LOGS + 3);
`endif

        row_dir[1] = 1'b0; row_speed[1] = 4'd2;
        log_x[1][0] = 10'd100; log_len[1][0] = 10'd96; log_valid[1][0] = 1'b1;
        log_valid[1][2] = 1'b0;
        start_frame(10, 64, mk(10, 0, 1, 0));
        finish_frame("water", NUM_LOGS + 3);

        check("overrun before", 32'(overrun), 32'd0);
        start_frame(77, 200, mk(77, 0, 0, 0));
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        finish_frame("no row", NUM_LOGS + 1);
        count_dones(12, cnt);
        check("single done", 32'(cnt), 32'd0);
        check("overrun set", 32'(overrun), 32'd1);

        // Abort during SCAN.
        frog_x = 10'd10; frog_y = 10'd64; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("busy mid scan", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort x_new", 32'(frog_x_new), 32'd0);
        check("abort overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        count_dones(10, cnt);
        check("abort no done", 32'(cnt), 32'd0);
        start_frame(10, 64, mk(10, 0, 1, 0));
        finish_frame("after abort", NUM_LOGS + 3);

`ifdef RIVER_SUBPIXEL_EN
        row_speed[1] = 4'h8;
        start_frame(120, 64, mk(120, 1, 0, 0));
        finish_frame("subpix f1", NUM_LOGS + 3);
        start_frame(120, 64, mk(121, 1, 0, 0));
        finish_frame("subpix f2", NUM_LOGS + 3);
        start_frame(121, 64, mk(121, 1, 0, 0));
        finish_frame("subpix f3", NUM_LOGS + 3);
        start_frame(121, 64, mk(122, 1, 0, 0));
        finish_frame("subpix f4", NUM_LOGS + 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
